// File: rtl/batch_cost_accumulator_pkg.sv
// Shared definitions for the batch cost accumulator: state encoding,
// default data/accumulator widths and the saturating-add width rule.
package batch_cost_accumulator_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ACC_W  = 24;

  // FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_ACCUM = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // An unsigned add of a DATA_W value (DATA_W <= ACC_W) into an ACC_W
  // accumulator needs one extra bit; that carry bit signals saturation.
  function automatic int sat_sum_w(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/batch_cost_accumulator_sat.sv
// One error channel: unsigned accumulator that clamps at its maximum value
// and remembers (until cleared) that a clamp happened.
module sat_accumulator
  import batch_cost_accumulator_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] in,
  output logic [ACC_W-1:0]  out,
  output logic              sat
);

  localparam int               SUM_W   = sat_sum_w(ACC_W);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [SUM_W-1:0] sum_next;

  // Full-width sum; the top bit set means the add overflowed the accumulator.
  always_comb begin
    sum_next = SUM_W'(out) + SUM_W'(in);
  end

  // Accumulate with clamp; clear takes priority over a same-cycle add.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      out <= '0;
      sat <= 1'b0;
    end else if (enable) begin
      if (sum_next[SUM_W-1]) begin
        out <= ACC_MAX;
        sat <= 1'b1;
      end else begin
        out <= sum_next[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/batch_cost_accumulator.sv
// Batch cost accumulator: waits out the forward-pipeline fill, sums BATCH
// per-channel squared-error vectors with saturation, then presents the
// per-channel sums and their total until the consumer takes them.
module batch_cost_accumulator
  import batch_cost_accumulator_pkg::*;
#(
  parameter int N_OUT   = 1,
  parameter int BATCH   = 16,
  parameter int LATENCY = 3,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ACC_W   = DEFAULT_ACC_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N_OUT*DATA_W-1:0]           error,
  output logic [N_OUT*ACC_W-1:0]            acc_error,
  output logic [ACC_W+$clog2(N_OUT)-1:0]    cost,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              sat
);

  localparam int COST_W = ACC_W + $clog2(N_OUT);
  // With no fill latency a batch goes straight to accumulation.
  localparam state_t           START_STATE = (LATENCY == 0) ? ST_ACCUM : ST_FILL;
  localparam logic [7:0]       FILL_LAST   = 8'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [15:0]      BATCH_LAST  = 16'(BATCH - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        fill_cnt_reg;
  logic [15:0]       sample_cnt_reg;
  logic              clear;
  logic              handshake;
  logic [N_OUT-1:0]  ch_sat;
  logic [COST_W-1:0] cost_sum;

  assign in_ready  = (state_reg == ST_ACCUM);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign handshake = in_ready & in_valid;
  assign sat       = |ch_sat;
  assign cost      = cost_sum;

  // Next-state logic; clear fires whenever a new batch is launched.
  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = START_STATE;
        end
      end
      ST_FILL: begin
        if (fill_cnt_reg == FILL_LAST) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (handshake && (sample_cnt_reg == BATCH_LAST)) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (start) begin
            clear      = 1'b1;
            state_next = START_STATE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus fill and sample counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      fill_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        fill_cnt_reg   <= '0;
        sample_cnt_reg <= '0;
      end else begin
        if (state_reg == ST_FILL) fill_cnt_reg <= fill_cnt_reg + 8'd1;
        if (handshake) sample_cnt_reg <= sample_cnt_reg + 16'd1;
      end
    end
  end

  // One saturating accumulator per error channel.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_ch
      sat_accumulator #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (handshake),
        .in     (error[gi*DATA_W +: DATA_W]),
        .out    (acc_error[gi*ACC_W +: ACC_W]),
        .sat    (ch_sat[gi])
      );
    end
  endgenerate

  // Total cost: wide enough that the channel sum never wraps.
  always_comb begin
    cost_sum = '0;
    for (int i = 0; i < N_OUT; i++) begin
      cost_sum = cost_sum + COST_W'(acc_error[i*ACC_W +: ACC_W]);
    end
  end

endmodule

// File: tb/tb_batch_cost_accumulator.sv
// Self-checking bench for batch_cost_accumulator. Three instances cover the
// main two-channel configuration, a narrow saturating accumulator and the
// zero-latency single-sample case.
module tb_batch_cost_accumulator;

  localparam int LAT_A = 3;
  localparam int B_A   = 4;
  localparam int LAT_B = 2;
  localparam int B_B   = 4;
  localparam longint MAX_A = (64'd1 << 24) - 1;
  localparam longint MAX_B = (64'd1 << 16) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N_OUT=2, BATCH=4, LATENCY=3, DATA_W=16, ACC_W=24
  logic        rst_a, start_a, inv_a, rdy_a, ov_a, ordy_a, busy_a, sat_a;
  logic [31:0] err_a;
  logic [47:0] acc_a;
  logic [24:0] cost_a;

  // Instance B: N_OUT=1, BATCH=4, LATENCY=2, DATA_W=16, ACC_W=16
  logic        rst_b, start_b, inv_b, rdy_b, ov_b, ordy_b, busy_b, sat_b;
  logic [15:0] err_b, acc_b, cost_b;

  // Instance C: N_OUT=1, BATCH=1, LATENCY=0, DATA_W=16, ACC_W=24
  logic        rst_c, start_c, inv_c, rdy_c, ov_c, ordy_c, busy_c, sat_c;
  logic [15:0] err_c;
  logic [23:0] acc_c, cost_c;

  batch_cost_accumulator #(.N_OUT(2), .BATCH(B_A), .LATENCY(LAT_A), .DATA_W(16), .ACC_W(24)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .in_valid(inv_a), .in_ready(rdy_a),
    .error(err_a), .acc_error(acc_a), .cost(cost_a), .out_valid(ov_a),
    .out_ready(ordy_a), .busy(busy_a), .sat(sat_a));

  batch_cost_accumulator #(.N_OUT(1), .BATCH(B_B), .LATENCY(LAT_B), .DATA_W(16), .ACC_W(16)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .in_valid(inv_b), .in_ready(rdy_b),
    .error(err_b), .acc_error(acc_b), .cost(cost_b), .out_valid(ov_b),
    .out_ready(ordy_b), .busy(busy_b), .sat(sat_b));

  batch_cost_accumulator #(.N_OUT(1), .BATCH(1), .LATENCY(0), .DATA_W(16), .ACC_W(24)) dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .in_valid(inv_c), .in_ready(rdy_c),
    .error(err_c), .acc_error(acc_c), .cost(cost_c), .out_valid(ov_c),
    .out_ready(ordy_c), .busy(busy_c), .sat(sat_c));

  // Expected results of the most recent batch on instance A.
  longint exp0, exp1, exp_cost;
  logic   exp_sat;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint clamp(input longint total, input longint maxv);
    return (total > maxv) ? maxv : total;
  endfunction

  // Count cycles after the start edge until in_ready shows up.
  task automatic wait_accum_a(input string tag);
    int n = 0;
    while (!rdy_a && n < 300) begin
      check({tag, "_fill_busy"}, 64'(busy_a), 64'd1);
      tick;
      n++;
    end
    check({tag, "_fill_len"}, 64'(n), 64'(LAT_A));
  endtask

  // Feed one batch on A; mode 0 = continuous, 1 = toggling, 2 = random valid.
  task automatic feed_a(input int mode, input bit fixed, input string tag);
    longint tot0 = 0, tot1 = 0;
    int     got = 0, cyc = 0;
    int     e0, e1;
    bit     v;
    while (got < B_A && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      e0 = fixed ? 1 : int'($urandom_range(0, 65535));
      e1 = fixed ? 2 : int'($urandom_range(0, 65535));
      err_a   = {16'(e1), 16'(e0)};
      inv_a   = v;
      start_a = 1'($urandom_range(0, 1));
      ordy_a  = 1'($urandom_range(0, 1));
      tick;
      cyc++;
      if (v) begin
        tot0 += e0;
        tot1 += e1;
        got++;
      end
      if (got < B_A) check({tag, "_early_ov"}, 64'(ov_a), 64'd0);
    end
    inv_a   = 1'b0;
    start_a = 1'b0;
    ordy_a  = 1'b0;
    exp0     = clamp(tot0, MAX_A);
    exp1     = clamp(tot1, MAX_A);
    exp_cost = exp0 + exp1;
    exp_sat  = (tot0 > MAX_A) || (tot1 > MAX_A);
    check({tag, "_ov"}, 64'(ov_a), 64'd1);
    check({tag, "_rdy_done"}, 64'(rdy_a), 64'd0);
    check({tag, "_acc0"}, 64'(acc_a[23:0]), 64'(exp0));
    check({tag, "_acc1"}, 64'(acc_a[47:24]), 64'(exp1));
    check({tag, "_cost"}, 64'(cost_a), 64'(exp_cost));
    check({tag, "_sat"}, 64'(sat_a), 64'(exp_sat));
    $display("batch %s: acc0=%0d acc1=%0d cost=%0d sat=%0b cycles=%0d",
             tag, acc_a[23:0], acc_a[47:24], cost_a, sat_a, cyc);
  endtask

  // Hand the result over and confirm it is held in IDLE, ignoring in_valid.
  task automatic release_a(input string tag);
    ordy_a = 1'b1;
    tick;
    ordy_a = 1'b0;
    inv_a  = 1'b1;
    err_a  = $urandom;
    check({tag, "_idle_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_idle_ov"}, 64'(ov_a), 64'd0);
    tick;
    inv_a = 1'b0;
    check({tag, "_hold_acc0"}, 64'(acc_a[23:0]), 64'(exp0));
    check({tag, "_hold_acc1"}, 64'(acc_a[47:24]), 64'(exp1));
    check({tag, "_hold_cost"}, 64'(cost_a), 64'(exp_cost));
    check({tag, "_hold_rdy"}, 64'(rdy_a), 64'd0);
  endtask

  task automatic start_a_batch(input string tag);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check({tag, "_clr_acc"}, 64'(acc_a), 64'd0);
    check({tag, "_clr_sat"}, 64'(sat_a), 64'd0);
    wait_accum_a(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint tot, lim;
    int     n, v;
    {rst_a, start_a, inv_a, ordy_a} = '0; err_a = '0;
    {rst_b, start_b, inv_b, ordy_b} = '0; err_b = '0;
    {rst_c, start_c, inv_c, ordy_c} = '0; err_c = '0;
    repeat (3) tick;

    // Reset state
    check("rst_rdy", 64'(rdy_a), 64'd0);
    check("rst_ov", 64'(ov_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_acc", 64'(acc_a), 64'd0);
    check("rst_cost", 64'(cost_a), 64'd0);
    check("rst_sat", 64'(sat_a), 64'd0);
    check("rst_b_busy", 64'(busy_b), 64'd0);
    check("rst_c_busy", 64'(busy_c), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick;

    // Continuous valid with {1,2}: sums {4,8}, cost 12
    start_a_batch("cont");
    feed_a(0, 1'b1, "cont");
    check("cont_const_cost", 64'(cost_a), 64'd12);
    release_a("cont");

    // Toggling valid, same values
    start_a_batch("toggle");
    feed_a(1, 1'b1, "toggle");
    release_a("toggle");

    // Held result for 5 cycles, then back-to-back start
    start_a_batch("hold");
    feed_a(2, 1'b0, "hold");
    for (int k = 0; k < 5; k++) begin
      start_a = 1'($urandom_range(0, 1));
      inv_a   = 1'b1;
      err_a   = $urandom;
      tick;
      check("hold_ov", 64'(ov_a), 64'd1);
      check("hold_acc", 64'(acc_a), {16'd0, 24'(exp1), 24'(exp0)});
      check("hold_cost", 64'(cost_a), 64'(exp_cost));
      check("hold_sat", 64'(sat_a), 64'(exp_sat));
    end
    inv_a   = 1'b0;
    ordy_a  = 1'b1;
    start_a = 1'b1;
    tick;
    ordy_a  = 1'b0;
    start_a = 1'b0;
    check("b2b_busy", 64'(busy_a), 64'd1);
    check("b2b_ov", 64'(ov_a), 64'd0);
    check("b2b_acc", 64'(acc_a), 64'd0);
    wait_accum_a("b2b");
    feed_a(2, 1'b0, "b2b");
    release_a("b2b");

    // Random batches
    for (int k = 0; k < 4; k++) begin
      start_a_batch("rand");
      feed_a(int'($urandom_range(0, 2)), 1'b0, "rand");
      release_a("rand");
    end

    // Mid-batch reset, then a fresh batch
    start_a_batch("mid");
    inv_a = 1'b1;
    repeat (2) begin
      err_a = $urandom;
      tick;
    end
    rst_a = 1'b0; start_a = 1'b1; inv_a = 1'b1; ordy_a = 1'b1;
    tick;
    check("mid_rst_acc", 64'(acc_a), 64'd0);
    check("mid_rst_cost", 64'(cost_a), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_rdy", 64'(rdy_a), 64'd0);
    check("mid_rst_ov", 64'(ov_a), 64'd0);
    tick;
    check("mid_rst_busy2", 64'(busy_a), 64'd0);
    rst_a = 1'b1; start_a = 1'b0; inv_a = 1'b0; ordy_a = 1'b0;
    tick;
    check("post_rst_busy", 64'(busy_a), 64'd0);
    start_a_batch("fresh");
    feed_a(0, 1'b0, "fresh");
    release_a("fresh");

    // Instance B: saturation at 0xFFFF
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    n = 0;
    while (!rdy_b && n < 300) begin tick; n++; end
    check("satb_fill_len", 64'(n), 64'(LAT_B));
    inv_b = 1'b1;
    err_b = 16'hFFFF;
    repeat (B_B) tick;
    inv_b = 1'b0;
    check("satb_ov", 64'(ov_b), 64'd1);
    check("satb_acc", 64'(acc_b), 64'hFFFF);
    check("satb_cost", 64'(cost_b), 64'hFFFF);
    check("satb_sat", 64'(sat_b), 64'd1);
    $display("batch satb: acc=%0h sat=%0b", acc_b, sat_b);
    for (int k = 0; k < 4; k++) begin
      ordy_b = 1'b1;
      start_b = 1'b1;
      tick;
      ordy_b = 1'b0;
      start_b = 1'b0;
      check("randb_clr_acc", 64'(acc_b), 64'd0);
      check("randb_clr_sat", 64'(sat_b), 64'd0);
      n = 0;
      while (!rdy_b && n < 300) begin tick; n++; end
      check("randb_fill_len", 64'(n), 64'(LAT_B));
      tot = 0;
      lim = (64'd1 << $urandom_range(12, 16)) - 1;
      inv_b = 1'b1;
      for (int s = 0; s < B_B; s++) begin
        v = int'($urandom_range(0, 32'(lim)));
        err_b = 16'(v);
        tot += v;
        tick;
      end
      inv_b = 1'b0;
      check("randb_ov", 64'(ov_b), 64'd1);
      check("randb_acc", 64'(acc_b), 64'(clamp(tot, MAX_B)));
      check("randb_sat", 64'(sat_b), 64'(tot > MAX_B));
      $display("batch randb: total=%0d acc=%0h sat=%0b", tot, acc_b, sat_b);
    end
    ordy_b = 1'b1;
    tick;
    ordy_b = 1'b0;
    check("randb_idle", 64'(busy_b), 64'd0);

    // Instance C: LATENCY=0, BATCH=1
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    check("lat0_rdy", 64'(rdy_c), 64'd1);
    inv_c = 1'b1;
    err_c = 16'd7;
    tick;
    inv_c = 1'b0;
    check("lat0_ov", 64'(ov_c), 64'd1);
    check("lat0_cost", 64'(cost_c), 64'd7);
    check("lat0_acc", 64'(acc_c), 64'd7);
    $display("batch lat0: cost=%0d", cost_c);
    ordy_c = 1'b1;
    tick;
    ordy_c = 1'b0;
    check("lat0_idle", 64'(busy_c), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/batch_cost_accumulator.md
BATCH_COST_ACCUMULATOR -- requirements
Module: batch_cost_accumulator

Interface
REQ-001 The block SHALL have parameter N_OUT, default 1: number of error channels (output-layer width).
REQ-002 The block SHALL have parameter BATCH, default 16: samples per batch, legal range 1 to 65535.
REQ-003 The block SHALL have parameter LATENCY, default 3: forward-pipeline fill cycles after start, legal range 0 to 255.
REQ-004 The block SHALL have parameter DATA_W, default 16: width of each squared-error input, unsigned.
REQ-005 The block SHALL have parameter ACC_W, default 24: per-channel accumulator width, at least DATA_W.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-007 Port reset, input, 1 bit: reset SHALL be synchronous and active-low (0 = reset).
REQ-008 Port start, input, 1 bit: begin a new batch.
REQ-009 Port in_valid, input, 1 bit: error vector valid.
REQ-010 Port in_ready, output, 1 bit: block accepts an error vector.
REQ-011 Port error, input, N_OUT x DATA_W: per-channel squared error for one sample.
REQ-012 Port acc_error, output, N_OUT x ACC_W: per-channel batch sums.
REQ-013 Port cost, output, ACC_W+clog2(N_OUT) bits (ACC_W when N_OUT=1): sum of all acc_error channels.
REQ-014 Port out_valid, output, 1 bit: batch result valid.
REQ-015 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port sat, output, 1 bit: sticky flag, set if any channel saturated during the current batch.

Function
REQ-018 The FSM SHALL have states IDLE, FILL, ACCUM and DONE.
REQ-019 In IDLE, start=1 SHALL clear all accumulators, the sample count and sat, then go to FILL, or to ACCUM when LATENCY=0.
REQ-020 FILL SHALL last exactly LATENCY cycles with in_ready=0, then go to ACCUM.
REQ-021 In ACCUM, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL add error[i] to acc_error[i] for every i.
REQ-022 Each addition SHALL be unsigned and saturate at 2^ACC_W-1; a saturating add SHALL set sat.
REQ-023 When the BATCH-th handshake occurs, the next state SHALL be DONE, and acc_error SHALL include that sample.
REQ-024 In DONE, out_valid SHALL be 1, in_ready SHALL be 0, and acc_error, cost and sat SHALL remain stable until out_ready=1.
REQ-025 In DONE, out_ready=1 with start=0 SHALL go to IDLE, and the results SHALL hold their values until the next start.
REQ-026 In DONE, out_ready=1 with start=1 SHALL clear the accumulators and go directly to FILL (or ACCUM), giving back-to-back batches with no IDLE cycle.
REQ-027 start SHALL be ignored in FILL, in ACCUM, and in DONE without out_ready.
REQ-028 cost SHALL be the combinational, non-saturating sum of the registered acc_error values.
REQ-029 in_valid SHALL be ignored outside ACCUM.
REQ-030 out_valid SHALL be 0 outside DONE.

Reset
REQ-031 When reset=0 on a rising edge, including mid-batch, the block SHALL enter IDLE and set acc_error, cost, the sample count, the fill count and sat to 0, and out_valid and in_ready to 0.
REQ-032 start, in_valid and out_ready SHALL have no effect in any cycle where reset=0.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the default DATA_W/ACC_W constants and the saturating-add width rule.
REQ-034 Each channel SHALL be one instance of sub-module sat_accumulator (clear, enable, in, out, sat), generated N_OUT times.

Verification
REQ-035 With N_OUT=2, BATCH=4, LATENCY=3, DATA_W=16, ACC_W=24: start, then error={1,2} valid continuously -> in_ready rises 3 cycles after start; out_valid 4 cycles later; acc_error={4,8}; cost=12; sat=0.
REQ-036 With the same configuration and in_valid toggling 1,0,1,0,...: the count advances only on handshakes; out_valid after the 4th accepted sample; sums match REQ-035.
REQ-037 With ACC_W=16, DATA_W=16, BATCH=4, error=0xFFFF each sample: acc_error=0xFFFF; sat=1; no wrap to a small value.
REQ-038 In DONE, hold out_ready=0 for 5 cycles, then assert out_ready together with start: results stay stable during the 5 cycles; the next batch starts with no IDLE cycle; the new acc_error starts from 0.
REQ-039 Assert reset=0 after 2 of 4 samples, then start a fresh batch: outputs are 0 during reset; the fresh batch result excludes the pre-reset samples.
REQ-040 With LATENCY=0 and BATCH=1: start, then one sample of 7 -> in_ready is 1 the cycle after start; out_valid the next cycle; cost=7.
